// File: rtl/otf_pkg.sv
// Shared definitions for the on-the-fly converter: FSM state encoding,
// signed-digit rail codes and the digit counter width helper.
package otf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        ACC
    } state_t;

    // {d_p, d_n} rail codes; 2'b11 is a redundant zero
    localparam logic [1:0] POS  = 2'b10;
    localparam logic [1:0] NEG  = 2'b01;
    localparam logic [1:0] ZERO = 2'b00;

    // Counter must reach both the skip length and the digit count
    function automatic int unsigned cnt_width(input int unsigned n, input int unsigned od);
        int unsigned m;
        m = (n > od) ? n : od;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/otf_converter_if.sv
// Stream/result bundle between the online adder side and the parallel side.
// Optional early-sign signals exist only when OTF_EARLY_SIGN_EN is defined.
interface otf_converter_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic         d_p;
    logic         d_n;
    logic         busy;
    logic         valid_out;
    logic [N:0]   z;
`ifdef OTF_EARLY_SIGN_EN
    logic         sign_valid;
    logic         sign;

    modport master (
        output start, d_p, d_n,
        input  busy, valid_out, z, sign_valid, sign
    );

    modport slave (
        input  start, d_p, d_n,
        output busy, valid_out, z, sign_valid, sign
    );
`else
    modport master (
        output start, d_p, d_n,
        input  busy, valid_out, z
    );

    modport slave (
        input  start, d_p, d_n,
        output busy, valid_out, z
    );
`endif
endinterface

// File: rtl/otf_digit_decode.sv
// Borrow-save digit decode: (d_p, d_n) to one-hot {pos, zero, neg}.
module otf_digit_decode
    import otf_pkg::*;
(
    input  logic d_p,
    input  logic d_n,
    output logic pos,
    output logic zero,
    output logic neg
);

    // Map the two rails to exactly one of the three digit values
    always_comb begin
        pos  = 1'b0;
        zero = 1'b0;
        neg  = 1'b0;
        case ({d_p, d_n})
            POS:     pos  = 1'b1;
            NEG:     neg  = 1'b1;
            ZERO:    zero = 1'b1;
            default: zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/otf_converter.sv
// On-the-fly converter: skips ONLINE_DELAY leading digits of a serial
// signed-digit stream, then builds an N-digit two's-complement result
// using the Q / QM = Q-1 register pair so no carry ever propagates.
// Optional feature macro: OTF_EARLY_SIGN_EN (adds sign_valid / sign).
module otf_converter
    import otf_pkg::*;
#(
    parameter int unsigned N            = 8,
    parameter int unsigned ONLINE_DELAY = 2
) (
    input  logic            clk,
    input  logic            rst,
    otf_converter_if.slave  bus
);

    localparam int unsigned    CW          = cnt_width(N, ONLINE_DELAY);
    localparam int unsigned    SKIP_LAST_I = (ONLINE_DELAY == 0) ? 0 : ONLINE_DELAY - 1;
    localparam logic [CW-1:0]  SKIP_LAST   = CW'(SKIP_LAST_I);
    localparam logic [CW-1:0]  ACC_LAST    = CW'(N - 1);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [N:0]     q;
    logic [N:0]     qm;
    logic [N:0]     q_nx;
    logic [N:0]     qm_nx;
    logic [N:0]     z_r;
    logic           valid_r;
    logic           busy;
    logic           pos;
    logic           zero;
    logic           neg;
    logic           start_ok;
    logic           skip_done;
    logic           acc_done;

    otf_digit_decode u_decode (
        .d_p  (bus.d_p),
        .d_n  (bus.d_n),
        .pos  (pos),
        .zero (zero),
        .neg  (neg)
    );

    assign start_ok  = (state == IDLE) && bus.start;
    assign skip_done = (state == SKIP) && (cnt == SKIP_LAST);
    assign acc_done  = (state == ACC)  && (cnt == ACC_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = (ONLINE_DELAY == 0) ? ACC : SKIP;
            SKIP: if (skip_done) state_nx = ACC;
            ACC:  if (acc_done)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Shift-append update of Q/QM for the current digit; the MSB falls off
    always_comb begin
        q_nx  = q;
        qm_nx = qm;
        if (pos) begin
            q_nx  = {q[N-1:0], 1'b1};
            qm_nx = {q[N-1:0], 1'b0};
        end
        if (zero) begin
            q_nx  = {q[N-1:0], 1'b0};
            qm_nx = {qm[N-1:0], 1'b1};
        end
        if (neg) begin
            q_nx  = {qm[N-1:0], 1'b1};
            qm_nx = {qm[N-1:0], 1'b0};
        end
    end

    // Digit counter, accumulator pair, result register and valid pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            q       <= '0;
            qm      <= '1;
            z_r     <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (start_ok) begin
                cnt <= '0;
                q   <= '0;
                qm  <= '1;
            end else if (state == SKIP) begin
                cnt <= skip_done ? '0 : cnt + CW'(1);
            end else if (state == ACC) begin
                q   <= q_nx;
                qm  <= qm_nx;
                cnt <= acc_done ? '0 : cnt + CW'(1);
                if (acc_done) begin
                    z_r     <= q_nx;
                    valid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.valid_out = valid_r;
    assign bus.z         = z_r;

`ifdef OTF_EARLY_SIGN_EN
    logic sign_r;
    logic sign_valid_r;

    // Sign is fixed by the first nonzero digit; an all-zero frame reports + at the end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_r       <= 1'b0;
            sign_valid_r <= 1'b0;
        end else if (start_ok) begin
            sign_r       <= 1'b0;
            sign_valid_r <= 1'b0;
        end else if ((state == ACC) && !sign_valid_r) begin
            if (!zero) begin
                sign_r       <= neg;
                sign_valid_r <= 1'b1;
            end else if (acc_done) begin
                sign_r       <= 1'b0;
                sign_valid_r <= 1'b1;
            end
        end
    end

    assign bus.sign       = sign_r;
    assign bus.sign_valid = sign_valid_r;
`endif

endmodule

// File: tb/tb_otf_converter.sv
// Directed, table-driven bench for otf_converter (N=8, ONLINE_DELAY=2).
// Sign checks are compiled in when OTF_EARLY_SIGN_EN is defined.
module tb_otf_converter;

    localparam int N  = 8;
    localparam int OD = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    otf_converter_if #(.N(N)) bus ();

    otf_converter #(
        .N            (N),
        .ONLINE_DELAY (OD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] dig;      // 8 digits, {d_p,d_n} pairs, first digit in [15:14]
        logic [8:0]  z_exp;
        int          sidx;     // accumulated digit after which sign_valid rises
        logic        sign_exp;
        int          spe;      // edge at which a stray start is pulsed (0 = none)
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts at the current (post-edge) time and returns right after the
    // edge that should raise valid_out, so a following call is back-to-back.
    task automatic run_frame(input vec_t v);
        int early_valid;
        int busy_bad;
        int sign_bad;
        int j;
        early_valid = 0;
        busy_bad    = 0;
        sign_bad    = 0;
        bus.start = 1'b1;
        {bus.d_p, bus.d_n} = 2'($urandom_range(0, 3));
        step();
        for (int k = 0; k <= OD + N; k++) begin
            if (k > 0) begin
                bus.start = (k == v.spe);
                if (k <= OD) begin
                    {bus.d_p, bus.d_n} = 2'($urandom_range(0, 3));
                end else begin
                    j = k - OD - 1;
                    {bus.d_p, bus.d_n} = v.dig[15 - 2*j -: 2];
                end
                step();
            end
            if (k < OD + N) begin
                if (bus.valid_out) early_valid++;
                if (!bus.busy) busy_bad++;
            end
`ifdef OTF_EARLY_SIGN_EN
            begin
                logic exp_sv;
                exp_sv = ((k - OD) >= v.sidx);
                if (bus.sign_valid !== exp_sv) sign_bad++;
                if (exp_sv && (bus.sign !== v.sign_exp)) sign_bad++;
                if (!exp_sv && (bus.sign !== 1'b0)) sign_bad++;
            end
`endif
        end
        bus.start = 1'b0;
        chk({v.name, " no_early_valid"}, early_valid, 0);
        chk({v.name, " busy_during"}, busy_bad, 0);
        chk({v.name, " valid_at_latency"}, {31'b0, bus.valid_out}, 1);
        chk({v.name, " busy_end"}, {31'b0, bus.busy}, 0);
        chk({v.name, " z"}, {23'b0, bus.z}, {23'b0, v.z_exp});
`ifdef OTF_EARLY_SIGN_EN
        chk({v.name, " sign_seq"}, sign_bad, 0);
`else
        if (sign_bad != 0) errors++;
`endif
    endtask

    initial begin
        int bad;
        logic [8:0] z_prev;

        vecs[0] = '{"all_pos",   16'hAAAA, 9'h0FF, 1, 1'b0, 0};
        vecs[1] = '{"mixed",     16'h9002, 9'h041, 1, 1'b0, 0};
        vecs[2] = '{"all_neg",   16'h5555, 9'h101, 1, 1'b1, 0};
        vecs[3] = '{"redundant", 16'hFFFD, 9'h1FF, 8, 1'b1, 0};
        vecs[4] = '{"mid_start", 16'h9002, 9'h041, 1, 1'b0, 5};
        vecs[5] = '{"all_zero",  16'h0000, 9'h000, 8, 1'b0, 0};
        vecs[6] = '{"mix_pos",   16'h2606, 9'h02F, 2, 1'b0, 0};
        vecs[7] = '{"mix_neg",   16'h0680, 9'h1F8, 3, 1'b1, 0};

        // Reset held with random stimulus
        rst = 1'b0;
        bus.start = 1'b0;
        bus.d_p = 1'b0;
        bus.d_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            {bus.d_p, bus.d_n} = 2'($urandom_range(0, 3));
            step();
            if (bus.busy || bus.valid_out || (bus.z != 9'h0)) bad++;
        end
        chk("reset busy", {31'b0, bus.busy}, 0);
        chk("reset valid", {31'b0, bus.valid_out}, 0);
        chk("reset z", {23'b0, bus.z}, 0);
        chk("reset hold_all", bad, 0);
`ifdef OTF_EARLY_SIGN_EN
        chk("reset sign", {30'b0, bus.sign_valid, bus.sign}, 0);
`endif

        // Idle after release
        bus.start = 1'b0;
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            {bus.d_p, bus.d_n} = 2'($urandom_range(0, 3));
            step();
            if (bus.busy || bus.valid_out) bad++;
        end
        chk("idle quiet", bad, 0);

        // Table: each frame followed by an idle cycle
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i]);
            z_prev = bus.z;
            {bus.d_p, bus.d_n} = 2'($urandom_range(0, 3));
            step();
            chk({vecs[i].name, " pulse_width"}, {31'b0, bus.valid_out}, 0);
            chk({vecs[i].name, " z_hold"}, {23'b0, bus.z}, {23'b0, vecs[i].z_exp});
        end

        // Back-to-back: second start lands in the valid_out cycle
        run_frame(vecs[0]);
        run_frame(vecs[7]);
        run_frame(vecs[1]);
        step();
        chk("b2b pulse_width", {31'b0, bus.valid_out}, 0);

        // Reset asserted in the 5th ACC cycle (before edge OD+5)
        bus.start = 1'b1;
        {bus.d_p, bus.d_n} = 2'b10;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= OD + 4; k++) begin
            {bus.d_p, bus.d_n} = 2'b10;
            step();
        end
        chk("abort pre busy", {31'b0, bus.busy}, 1);
        rst = 1'b0;
        #1;
        chk("abort z", {23'b0, bus.z}, 0);
        chk("abort busy", {31'b0, bus.busy}, 0);
        chk("abort valid", {31'b0, bus.valid_out}, 0);
`ifdef OTF_EARLY_SIGN_EN
        chk("abort sign", {30'b0, bus.sign_valid, bus.sign}, 0);
`endif
        step();
        step();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            {bus.d_p, bus.d_n} = 2'b10;
            step();
            if (bus.valid_out || bus.busy || (bus.z != 9'h0)) bad++;
        end
        chk("abort no_valid", bad, 0);

        // Recovery frame after the abort
        run_frame(vecs[2]);
        step();
        chk("recover pulse_width", {31'b0, bus.valid_out}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
